hex_disp_ctrl: RTL

- Parametrised seven-segment display controller. Replaces per-digit HexDriver instances and hand-built sign/hundreds segment logic in top-levels.
- Accepts a WIDTH-bit value, either signed or unsigned, through a start/busy/done handshake.
- Converts the value to hex, or to decimal using a sequential double-dabble.
- Drives DIGITS active-low segment bytes, with a minus sign and overflow indication.

---
 rtl/hex_disp_ctrl_pkg.sv | 28 ++
 rtl/hex_disp_ctrl_if.sv | 27 ++
 rtl/hex_disp_ctrl_seg7_lut.sv | 13 +
 rtl/hex_disp_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/hex_disp_ctrl_pkg.sv
// Shared types and constants for the seven-segment display controller.
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, blank/minus segment codes, hex glyph table, BCD digit count helper.
package hex_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    ENCODE
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Active-low {dp, g, f, e, d, c, b, a} glyphs for nibble values 0..F.
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Decimal digits needed for a width-bit magnitude (log10(2) ~ 0.3, rounded up).
  function automatic int bcd_digits(input int width);
    return (width * 3) / 10 + 1;
  endfunction

endpackage

// File: rtl/hex_disp_ctrl_if.sv
// Request/result bundle between a display client and hex_disp_ctrl.
// Latency: none (wiring only).
// Backpressure: start is only honoured while busy is low; no queueing.
// Ports: start/mode/is_signed/value from client; busy/done/ovf/segs_n from controller.
interface hex_disp_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 6
);
  logic                  start;
  logic                  mode;
  logic                  is_signed;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [DIGITS*8-1:0]   segs_n;

  modport master (
    output start, mode, is_signed, value,
    input  busy, done, ovf, segs_n
  );

  modport slave (
    input  start, mode, is_signed, value,
    output busy, done, ovf, segs_n
  );
endinterface

// File: rtl/hex_disp_ctrl_seg7_lut.sv
// Nibble to active-low seven-segment glyph encoder (dp held off).
// Latency: combinational.
// Backpressure: n/a.
// Ports: nib in (4b), seg_n out (8b, bit 7 = dp, bits 6:0 = gfedcba).
module seg7_lut (
  input  logic [3:0] nib,
  output logic [7:0] seg_n
);
  import hex_disp_pkg::*;

  assign seg_n = SEG_LUT[nib];

endmodule

// File: rtl/hex_disp_ctrl.sv
// Converts a signed/unsigned value to hex or decimal seven-segment digits.
// Latency: hex 2 edges, decimal WIDTH+2 edges after the accepting edge; done pulses 1 cycle.
// Backpressure: start ignored while busy; a new start may be taken in the done cycle.
// Ports: Clk, Reset (async, active-high), bus (hex_disp_ctrl_if.slave).
// Build option: HEX_DISP_BLANK_EN blanks leading zeros and floats the minus sign next to the number.
module hex_disp_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 6
) (
  input  logic           Clk,
  input  logic           Reset,
  hex_disp_ctrl_if.slave bus
);
  import hex_disp_pkg::*;

  localparam int BCD_DIGITS = bcd_digits(WIDTH);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  // Digit span examined for significance: covers every BCD/hex digit and every display slot.
  localparam int ALL        = (BCD_DIGITS > DIGITS) ? BCD_DIGITS : DIGITS;
  localparam int CW         = $clog2(WIDTH);

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    val_r;
  logic [WIDTH-1:0]    mag_r;
  logic                mode_r;
  logic                signed_r;
  logic                neg_r;
  logic [BCD_W-1:0]    bcd_r;
  logic [BCD_W-1:0]    bcd_adj;
  logic [CW-1:0]       cnt;
  logic                done_r;
  logic                ovf_r;
  logic                ovf_nxt;
  logic [DIGITS*8-1:0] segs_r;
  logic [DIGITS*8-1:0] segs_nxt;
  logic [4*ALL-1:0]    dig_flat;
  logic [7:0]          lut_seg [DIGITS];
  int                  n;

  // ---------------- FSM ----------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = mode_r ? SHIFT : ENCODE;
      SHIFT:   if (cnt == CW'(WIDTH - 1)) state_nxt = ENCODE;
      ENCODE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- double-dabble add-3 ----------------
  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      val_r    <= '0;
      mag_r    <= '0;
      mode_r   <= 1'b0;
      signed_r <= 1'b0;
      neg_r    <= 1'b0;
      bcd_r    <= '0;
      cnt      <= '0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      segs_r   <= '1;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            val_r    <= bus.value;
            mode_r   <= bus.mode;
            signed_r <= bus.is_signed;
          end
        end
        LOAD: begin
          // Negating the most negative value wraps to 2^(WIDTH-1), which is the right magnitude.
          neg_r <= signed_r & val_r[WIDTH-1];
          mag_r <= (signed_r & val_r[WIDTH-1]) ? (~val_r + WIDTH'(1)) : val_r;
          bcd_r <= '0;
          cnt   <= '0;
        end
        SHIFT: begin
          // Shift {bcd, mag} left one bit; the carry out of the top BCD nibble is always zero.
          bcd_r <= BCD_W'({bcd_adj, mag_r[WIDTH-1]});
          mag_r <= mag_r << 1;
          cnt   <= cnt + CW'(1);
        end
        ENCODE: begin
          segs_r <= segs_nxt;
          ovf_r  <= ovf_nxt;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- encode ----------------
  // In hex mode mag_r is untouched; in decimal mode the result sits in bcd_r.
  assign dig_flat = mode_r ? (4*ALL)'(bcd_r) : (4*ALL)'(mag_r);

  for (genvar g = 0; g < DIGITS; g++) begin : g_lut
    seg7_lut u_lut (
      .nib   (dig_flat[4*g +: 4]),
      .seg_n (lut_seg[g])
    );
  end

  always_comb begin
    n        = 1;
    segs_nxt = '1;
    for (int i = 0; i < ALL; i++) begin
      if (dig_flat[4*i +: 4] != 4'd0) n = i + 1;
    end
    ovf_nxt = (n + int'(neg_r)) > DIGITS;
`ifdef HEX_DISP_BLANK_EN
    for (int i = 0; i < DIGITS; i++) begin
      if (i < n)                 segs_nxt[8*i +: 8] = lut_seg[i];
      else if (neg_r && i == n)  segs_nxt[8*i +: 8] = SEG_MINUS;
      else                       segs_nxt[8*i +: 8] = SEG_BLANK;
    end
`else
    // The minus sign occupies the leftmost slot, so a digit there cannot be shown.
    if (neg_r && dig_flat[4*(DIGITS-1) +: 4] != 4'd0) ovf_nxt = 1'b1;
    for (int i = 0; i < DIGITS; i++) segs_nxt[8*i +: 8] = lut_seg[i];
    if (neg_r) segs_nxt[8*(DIGITS-1) +: 8] = SEG_MINUS;
`endif
    if (ovf_nxt) segs_nxt = {DIGITS{SEG_MINUS}};
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_r;
  assign bus.ovf    = ovf_r;
  assign bus.segs_n = segs_r;

endmodule
